// File: rtl/bootrom_axil_pkg.sv
// State encodings and AXI response codes shared by the boot ROM AXI4-Lite arbiter.
package bootrom_axil_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } r_state_e;

  typedef enum logic [2:0] {
    W_IDLE  = 3'd0,
    W_FWD   = 3'd1,
    W_B     = 3'd2,
    W_ERR   = 3'd3,
    W_ERR_B = 3'd4
  } w_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/bootrom_axil_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_c,
  output logic       any_c
);

  always_comb begin
    gnt_c = 1'b0;
    any_c = |req_i;
    case (req_i)
      2'b01:   gnt_c = 1'b0;
      2'b10:   gnt_c = 1'b1;
      2'b11:   gnt_c = ~last_i;
      default: gnt_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/bootrom_axil_arbiter.sv
// Shares the boot ROM AXI4-Lite slave port between the host loader (s0) and the core (s1).
// Read and write channels are arbitrated independently with one transaction each in flight.
module bootrom_axil_arbiter
  import bootrom_axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter bit          S1_WRITE_EN = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s0_axilite_awvalid,
  output logic                      s0_axilite_awready,
  input  logic [ADDR_WIDTH-1:0]     s0_axilite_awaddr,
  input  logic [2:0]                s0_axilite_awprot,
  input  logic                      s0_axilite_wvalid,
  output logic                      s0_axilite_wready,
  input  logic [DATA_WIDTH-1:0]     s0_axilite_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s0_axilite_wstrb,
  output logic                      s0_axilite_bvalid,
  input  logic                      s0_axilite_bready,
  output logic [1:0]                s0_axilite_bresp,
  input  logic                      s0_axilite_arvalid,
  output logic                      s0_axilite_arready,
  input  logic [ADDR_WIDTH-1:0]     s0_axilite_araddr,
  input  logic [2:0]                s0_axilite_arprot,
  output logic                      s0_axilite_rvalid,
  input  logic                      s0_axilite_rready,
  output logic [DATA_WIDTH-1:0]     s0_axilite_rdata,
  output logic [1:0]                s0_axilite_rresp,
  input  logic                      s1_axilite_awvalid,
  output logic                      s1_axilite_awready,
  input  logic [ADDR_WIDTH-1:0]     s1_axilite_awaddr,
  input  logic [2:0]                s1_axilite_awprot,
  input  logic                      s1_axilite_wvalid,
  output logic                      s1_axilite_wready,
  input  logic [DATA_WIDTH-1:0]     s1_axilite_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_axilite_wstrb,
  output logic                      s1_axilite_bvalid,
  input  logic                      s1_axilite_bready,
  output logic [1:0]                s1_axilite_bresp,
  input  logic                      s1_axilite_arvalid,
  output logic                      s1_axilite_arready,
  input  logic [ADDR_WIDTH-1:0]     s1_axilite_araddr,
  input  logic [2:0]                s1_axilite_arprot,
  output logic                      s1_axilite_rvalid,
  input  logic                      s1_axilite_rready,
  output logic [DATA_WIDTH-1:0]     s1_axilite_rdata,
  output logic [1:0]                s1_axilite_rresp,
  output logic                      m_axilite_awvalid,
  input  logic                      m_axilite_awready,
  output logic [ADDR_WIDTH-1:0]     m_axilite_awaddr,
  output logic [2:0]                m_axilite_awprot,
  output logic                      m_axilite_wvalid,
  input  logic                      m_axilite_wready,
  output logic [DATA_WIDTH-1:0]     m_axilite_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axilite_wstrb,
  input  logic                      m_axilite_bvalid,
  output logic                      m_axilite_bready,
  input  logic [1:0]                m_axilite_bresp,
  output logic                      m_axilite_arvalid,
  input  logic                      m_axilite_arready,
  output logic [ADDR_WIDTH-1:0]     m_axilite_araddr,
  output logic [2:0]                m_axilite_arprot,
  input  logic                      m_axilite_rvalid,
  output logic                      m_axilite_rready,
  input  logic [DATA_WIDTH-1:0]     m_axilite_rdata,
  input  logic [1:0]                m_axilite_rresp
);

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  logic     r_gnt_q, r_gnt_d, r_last_q, r_last_d;
  logic     w_gnt_q, w_gnt_d, w_last_q, w_last_d;
  logic     aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic     r_pick, r_any, w_pick, w_any;
  logic     aw_hs, w_hs;

  rr_arb2 u_rd_arb (
    .req_i  ({s1_axilite_arvalid, s0_axilite_arvalid}),
    .last_i (r_last_q),
    .gnt_c  (r_pick),
    .any_c  (r_any)
  );

  rr_arb2 u_wr_arb (
    .req_i  ({s1_axilite_awvalid, s0_axilite_awvalid}),
    .last_i (w_last_q),
    .gnt_c  (w_pick),
    .any_c  (w_any)
  );

  // Pointers reset to "s1 granted last" so the first tie goes to s0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_gnt_q   <= 1'b0;
      r_last_q  <= 1'b1;
      w_state_q <= W_IDLE;
      w_gnt_q   <= 1'b0;
      w_last_q  <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_gnt_q   <= r_gnt_d;
      r_last_q  <= r_last_d;
      w_state_q <= w_state_d;
      w_gnt_q   <= w_gnt_d;
      w_last_q  <= w_last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Read channel: grant in idle, then pass AR and R straight through for the winner.
  always_comb begin
    r_state_d          = r_state_q;
    r_gnt_d            = r_gnt_q;
    r_last_d           = r_last_q;
    m_axilite_arvalid  = 1'b0;
    m_axilite_araddr   = '0;
    m_axilite_arprot   = '0;
    m_axilite_rready   = 1'b0;
    s0_axilite_arready = 1'b0;
    s1_axilite_arready = 1'b0;
    s0_axilite_rvalid  = 1'b0;
    s0_axilite_rdata   = '0;
    s0_axilite_rresp   = RESP_OKAY;
    s1_axilite_rvalid  = 1'b0;
    s1_axilite_rdata   = '0;
    s1_axilite_rresp   = RESP_OKAY;
    case (r_state_q)
      R_IDLE: begin
        if (r_any) begin
          r_gnt_d   = r_pick;
          r_state_d = R_AR;
        end
      end
      R_AR: begin
        m_axilite_arvalid = r_gnt_q ? s1_axilite_arvalid : s0_axilite_arvalid;
        m_axilite_araddr  = r_gnt_q ? s1_axilite_araddr : s0_axilite_araddr;
        m_axilite_arprot  = r_gnt_q ? s1_axilite_arprot : s0_axilite_arprot;
        if (r_gnt_q) s1_axilite_arready = m_axilite_arready;
        else         s0_axilite_arready = m_axilite_arready;
        if ((r_gnt_q ? s1_axilite_arvalid : s0_axilite_arvalid) && m_axilite_arready)
          r_state_d = R_R;
      end
      R_R: begin
        m_axilite_rready = r_gnt_q ? s1_axilite_rready : s0_axilite_rready;
        if (r_gnt_q) begin
          s1_axilite_rvalid = m_axilite_rvalid;
          s1_axilite_rdata  = m_axilite_rdata;
          s1_axilite_rresp  = m_axilite_rresp;
        end else begin
          s0_axilite_rvalid = m_axilite_rvalid;
          s0_axilite_rdata  = m_axilite_rdata;
          s0_axilite_rresp  = m_axilite_rresp;
        end
        if (m_axilite_rvalid && (r_gnt_q ? s1_axilite_rready : s0_axilite_rready)) begin
          r_state_d = R_IDLE;
          r_last_d  = r_gnt_q;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write channel: AW and W complete independently, tracked by sticky done flags.
  always_comb begin
    w_state_d          = w_state_q;
    w_gnt_d            = w_gnt_q;
    w_last_d           = w_last_q;
    aw_done_d          = aw_done_q;
    w_done_d           = w_done_q;
    aw_hs              = 1'b0;
    w_hs               = 1'b0;
    m_axilite_awvalid  = 1'b0;
    m_axilite_awaddr   = '0;
    m_axilite_awprot   = '0;
    m_axilite_wvalid   = 1'b0;
    m_axilite_wdata    = '0;
    m_axilite_wstrb    = '0;
    m_axilite_bready   = 1'b0;
    s0_axilite_awready = 1'b0;
    s0_axilite_wready  = 1'b0;
    s0_axilite_bvalid  = 1'b0;
    s0_axilite_bresp   = RESP_OKAY;
    s1_axilite_awready = 1'b0;
    s1_axilite_wready  = 1'b0;
    s1_axilite_bvalid  = 1'b0;
    s1_axilite_bresp   = RESP_OKAY;
    case (w_state_q)
      W_IDLE: begin
        if (w_any) begin
          w_gnt_d   = w_pick;
          w_state_d = (w_pick && !S1_WRITE_EN) ? W_ERR : W_FWD;
        end
      end
      W_FWD: begin
        m_axilite_awvalid = ~aw_done_q & (w_gnt_q ? s1_axilite_awvalid : s0_axilite_awvalid);
        m_axilite_awaddr  = w_gnt_q ? s1_axilite_awaddr : s0_axilite_awaddr;
        m_axilite_awprot  = w_gnt_q ? s1_axilite_awprot : s0_axilite_awprot;
        m_axilite_wvalid  = ~w_done_q & (w_gnt_q ? s1_axilite_wvalid : s0_axilite_wvalid);
        m_axilite_wdata   = w_gnt_q ? s1_axilite_wdata : s0_axilite_wdata;
        m_axilite_wstrb   = w_gnt_q ? s1_axilite_wstrb : s0_axilite_wstrb;
        if (w_gnt_q) begin
          s1_axilite_awready = m_axilite_awready & ~aw_done_q;
          s1_axilite_wready  = m_axilite_wready & ~w_done_q;
        end else begin
          s0_axilite_awready = m_axilite_awready & ~aw_done_q;
          s0_axilite_wready  = m_axilite_wready & ~w_done_q;
        end
        aw_hs = ~aw_done_q & m_axilite_awready &
                (w_gnt_q ? s1_axilite_awvalid : s0_axilite_awvalid);
        w_hs  = ~w_done_q & m_axilite_wready &
                (w_gnt_q ? s1_axilite_wvalid : s0_axilite_wvalid);
      end
      W_B: begin
        m_axilite_bready = w_gnt_q ? s1_axilite_bready : s0_axilite_bready;
        if (w_gnt_q) begin
          s1_axilite_bvalid = m_axilite_bvalid;
          s1_axilite_bresp  = m_axilite_bresp;
        end else begin
          s0_axilite_bvalid = m_axilite_bvalid;
          s0_axilite_bresp  = m_axilite_bresp;
        end
        if (m_axilite_bvalid && (w_gnt_q ? s1_axilite_bready : s0_axilite_bready)) begin
          w_state_d = W_IDLE;
          w_last_d  = w_gnt_q;
        end
      end
      W_ERR: begin
        s1_axilite_awready = ~aw_done_q;
        s1_axilite_wready  = ~w_done_q;
        aw_hs = ~aw_done_q & s1_axilite_awvalid;
        w_hs  = ~w_done_q & s1_axilite_wvalid;
      end
      W_ERR_B: begin
        s1_axilite_bvalid = 1'b1;
        s1_axilite_bresp  = RESP_SLVERR;
        if (s1_axilite_bready) begin
          w_state_d = W_IDLE;
          w_last_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    // Both halves landed (possibly in the same cycle): move on to the response.
    if (w_state_q == W_FWD || w_state_q == W_ERR) begin
      if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        w_state_d = (w_state_q == W_FWD) ? W_B : W_ERR_B;
      end else begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
      end
    end
  end

endmodule

// File: doc/bootrom_axil_arbiter.md
Name: bootrom_axil_arbiter

Overview:
- Shares the single AXI4-Lite slave port of the boot ROM/RAM between two masters.
- s0 is the host loader, which writes the boot image. s1 is the core's fetch/uncached path.
- Read and write channels are arbitrated independently, one outstanding transaction per channel, round-robin between requesters.
- s1 writes can be blocked by a parameter, which protects the boot image from the core.

Parameters:
- ADDR_WIDTH, 16, address width on all ports.
- DATA_WIDTH, 32, data width on all ports; strobe width is DATA_WIDTH/8.
- S1_WRITE_EN, 0, if 0, s1 writes are never forwarded and complete with SLVERR.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sN_axilite_aw{valid,ready,addr,prot}, N=0,1  slave  1/1/ADDR_WIDTH/3  write address from master N
- sN_axilite_w{valid,ready,data,strb}  slave  1/1/DATA_WIDTH/DATA_WIDTH/8  write data from master N
- sN_axilite_b{valid,ready,resp}  slave  1/1/2  write response to master N
- sN_axilite_ar{valid,ready,addr,prot}  slave  1/1/ADDR_WIDTH/3  read address from master N
- sN_axilite_r{valid,ready,data,resp}  slave  1/1/DATA_WIDTH/2  read data to master N
- m_axilite_{aw,w,b,ar,r}*  master  same widths  single downstream port to the boot ROM

Behaviour:
- Reset (async assert, sync deassert by the surrounding logic):
  - Both FSMs go to IDLE.
  - Every valid/ready output is 0; data/addr outputs are 0.
  - Both round-robin pointers favour s0.
- Read FSM R_IDLE -> R_AR -> R_R -> R_IDLE:
  - R_IDLE: the grant is registered from the sN_arvalid values. Single requester wins. If both request, the one not granted last wins. Move to R_AR next cycle. No ready is asserted in R_IDLE.
  - R_AR: m_ar* is a combinational mux of the granted slave; granted sN_arready = m_arready; the other slave's arready = 0. On handshake go to R_R.
  - R_R: granted sN_r* = m_r*; m_rready = granted sN_rready; the other slave's rvalid = 0. On handshake go to R_IDLE and the pointer records the winner.
- Write FSM W_IDLE -> W_FWD -> W_B -> W_IDLE, plus W_ERR -> W_ERR_B:
  - W_IDLE: grant is chosen from sN_awvalid with the same round-robin rule. If the winner is s1 and S1_WRITE_EN=0, go to W_ERR; otherwise go to W_FWD.
  - W_FWD: AW and W are forwarded independently. Sticky flags aw_done and w_done are set on each handshake, and a channel's valid/ready is masked once its flag is set. When both flags are set (same cycle allowed), clear them and go to W_B.
  - W_B: granted sN_b* = m_b*, m_bready = granted sN_bready. On handshake go to W_IDLE and update the pointer.
  - W_ERR: master port untouched. s1_awready and s1_wready are driven by the arbiter itself, 1 until each handshakes, using the same done flags; then go to W_ERR_B.
  - W_ERR_B: s1_bvalid = 1, s1_bresp = 2'b10. On s1_bready go to W_IDLE and update the pointer.
- The read and write FSMs may be active in the same cycle with different masters.
- Worst-case added latency: 1 cycle at the arbitration edge. Address, data and response paths are otherwise combinational pass-through.
- A request that drops valid before grant is legal to ignore, since AXI forbids it. Grant is re-evaluated only in IDLE.
- Reset mid-transaction abandons the in-flight beat; the ROM is reset on the same rst_n domain.
- prot is passed through unchanged; no address decode; every address is forwarded.

Decomposition:
- Package bootrom_axil_pkg holds:
  - R_* and W_* state encodings (2-bit read, 3-bit write);
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
- Sub-module rr_arb2 is a 2-way round-robin picker: req[1:0], last grant -> grant index. It is instantiated once per channel FSM.

Test Plan:
- Reset held low, both masters issuing arvalid/awvalid -> all ready/valid outputs 0; m_arvalid = 0.
- s1 read addr 0x0004, ROM returns 0x01f29293 -> s1 rdata = 0x01f29293, rresp = 0; s0 arready/rvalid stay 0.
- s0 and s1 arvalid together, three back-to-back rounds -> grant order s0, s1, s0; each master gets its own address's data.
- s0 write addr 0x0008, data 0x00028067, strb 0xF, with W before AW by 2 cycles -> one m_aw and one m_w handshake; s0 bresp = 0; read-back returns 0x00028067.
- S1_WRITE_EN = 0, s1 write to 0x0000 -> no m_awvalid/m_wvalid; s1 bresp = 2'b10; a concurrent s0 read completes unaffected.
- rst_n pulsed low during R_R with m_rvalid = 1 -> FSM back in R_IDLE; s0_rvalid = 0 within the same cycle as reset assertion.
